// File: rtl/multiword_add_sequencer.sv
// Wide adder controller: streams an N*WORDS-bit addition through one external
// N-bit adder, LSB chunk first, carrying between chunks in a register.
module multiword_add_sequencer #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N*WORDS-1:0]   op_a,
  input  logic [N*WORDS-1:0]   op_b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout,
  output logic [N-1:0]         add_inp1,
  output logic [N-1:0]         add_inp2,
  output logic                 add_cin,
  input  logic [N-1:0]         add_result,
  input  logic                 add_cout
);

  localparam int W     = N * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       acc_q;
  logic [W-1:0]       acc_d;
  logic [W-1:0]       sum_q;
  logic               carry_q;
  logic               cout_q;
  logic [IDX_W-1:0]   idx_q;

  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

  // The adder only sees operands while a chunk is in flight; otherwise it idles at zero.
  always_comb begin
    add_inp1 = '0;
    add_inp2 = '0;
    add_cin  = 1'b0;
    if (state_q == RUN) begin
      add_inp1 = a_q[idx_q*N +: N];
      add_inp2 = b_q[idx_q*N +: N];
      add_cin  = carry_q;
    end
  end

  // Accumulator with the current chunk merged in, so the final sum can be
  // taken in the same edge as the last chunk without a special slice for WORDS=1.
  always_comb begin
    acc_d = acc_q;
    acc_d[idx_q*N +: N] = add_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= op_a;
            b_q     <= op_b;
            carry_q <= cin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= add_cout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            sum_q   <= acc_d;
            cout_q  <= add_cout;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
